// File: rtl/irq_pending_ctrl_pkg.sv
// irq_pending_ctrl shared definitions.
// Widths, FSM encodings and helpers.
package irq_pending_ctrl_pkg;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    typedef logic [NUM_IRQ-1:0] irq_vec_t;
    typedef logic [ID_W-1:0]    irq_id_t;

    function automatic irq_vec_t id_onehot(input irq_id_t id);
        irq_vec_t v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Presentation handshake between the
// pending controller and its consumer.
interface irq_pending_ctrl_if;
    import irq_pending_ctrl_pkg::*;

    logic    irq_valid;
    irq_id_t irq_id;
    logic    ack;

    modport master (
        output irq_valid,
        output irq_id,
        input  ack
    );

    modport slave (
        input  irq_valid,
        input  irq_id,
        output ack
    );

endinterface

// File: rtl/irq_prio_enc8.sv
// Combinational 8-to-3 highest-bit
// encoder; bit 7 has top priority.
module irq_prio_enc8
    import irq_pending_ctrl_pkg::*;
(
    input  irq_vec_t req,
    output irq_id_t  id,
    output logic     found
);

    // Ascending scan so the highest set bit is written last
    always_comb begin
        id    = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) begin
                id    = ID_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/mask front end with
// a valid/ack presentation handshake.
module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
#(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  irq_vec_t                  irq,
    input  irq_vec_t                  mask,
    input  logic                      clr_all,
    output irq_vec_t                  pending,
    output irq_vec_t                  lost,
    irq_pending_ctrl_if.master        bus
);

    irq_vec_t   irq_s;
    irq_vec_t   irq_d;
    irq_vec_t   irq_edge;
    irq_vec_t   ack_clr;
    irq_vec_t   cand;
    irq_vec_t   pend_q;
    irq_vec_t   lost_q;
    logic [0:0] state;
    irq_id_t    id_q;
    irq_id_t    win_id;
    logic       win_found;
    logic       ack_hit;

    generate
        if (SYNC_EN) begin : g_sync
            irq_vec_t s1;
            irq_vec_t s2;
            // Two-flop synchronizer per request line
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1 <= '0;
                    s2 <= '0;
                end else begin
                    s1 <= irq;
                    s2 <= s1;
                end
            end
            assign irq_s = s2;
        end else begin : g_nosync
            assign irq_s = irq;
        end
    endgenerate

    // Delayed copy for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_d <= '0;
        end else begin
            irq_d <= irq_s;
        end
    end

    assign irq_edge = irq_s & ~irq_d;
    assign ack_hit  = (state == ST_PRESENT) && bus.ack;
    assign ack_clr  = ack_hit ? id_onehot(id_q) : '0;
    assign cand     = pend_q & mask;

    irq_prio_enc8 u_enc (
        .req   (cand),
        .id    (win_id),
        .found (win_found)
    );

    // Sticky pending/lost; new edge beats ack clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            lost_q <= '0;
        end else if (clr_all) begin
            pend_q <= '0;
            lost_q <= '0;
        end else begin
            pend_q <= (pend_q & ~ack_clr) | irq_edge;
            lost_q <= lost_q
                    | (irq_edge & pend_q & ~ack_clr);
        end
    end

    // Present/ack FSM; id frozen while presenting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            id_q  <= '0;
        end else if (clr_all) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        id_q  <= win_id;
                        state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (bus.ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.irq_valid = (state == ST_PRESENT);
    assign bus.irq_id    = id_q;
    assign pending       = pend_q;
    assign lost          = lost_q;

endmodule
